// File: rtl/key_ctrl_pkg.sv
// Shared constants and helpers for the key mode controller.
// Used by key_mode_ctrl and key_win_timer.
package key_ctrl_pkg;

   localparam int CNT_W  = 24;
   localparam int CH_NUM = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT2  = 2'd1;
   localparam logic [1:0] ST_OS_RST = 2'd2;

   localparam logic [2:0] OS_NONE = 3'd0;
   localparam logic [2:0] OS_2    = 3'd1;
   localparam logic [2:0] OS_4    = 3'd2;
   localparam logic [2:0] OS_8    = 3'd3;
   localparam logic [2:0] OS_16   = 3'd4;
   localparam logic [2:0] OS_32   = 3'd5;
   localparam logic [2:0] OS_64   = 3'd6;

   // Wraps at os_max; an out-of-range 7 also returns to 0 via the 3-bit add.
   function automatic logic [2:0] os_next(input logic [2:0] cur, input logic [2:0] os_max);
      return (cur == os_max) ? OS_NONE : cur + 3'd1;
   endfunction

   function automatic logic [2:0] ch_next(input logic [2:0] cur);
      return (cur == 3'(CH_NUM - 1)) ? 3'd0 : cur + 3'd1;
   endfunction

endpackage

// File: rtl/key_win_timer.sv
// Loadable up-counter with clear, enable and terminal-count compare.
// tc_low restricts the compare to the low 8 bits (short pulse timing).
module key_win_timer
   import key_ctrl_pkg::*;
(
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic [CNT_W-1:0] tc_val,
   input  logic             tc_low,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = tc_low ? (cnt[7:0] == tc_val[7:0]) : (cnt == tc_val);

endmodule

// File: rtl/key_mode_ctrl.sv
// Single/double click classifier driving AD7606 channel select and OS code.
// Macro KEY_DBLCLK_EN builds the double-click path; otherwise every press steps ch_sel.
module key_mode_ctrl
   import key_ctrl_pkg::*;
#(
   parameter logic [23:0] WIN_MAX = 24'd14_999_999,
   parameter logic [7:0]  RST_LEN = 8'd9,
   parameter logic [2:0]  OS_MAX  = OS_64,
   parameter logic [2:0]  OS_INIT = OS_NONE
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_flag,
   output logic [2:0] ch_sel,
   output logic [2:0] os,
   output logic       ad_rst_req,
   output logic       ch_chg,
   output logic       busy
);

   // Press pulse is registered first so every decision works from a flopped input.
   logic key_flag_p0;

`ifdef KEY_DBLCLK_EN

   logic [1:0]       state;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_low;
   logic             tmr_tc;
   logic [CNT_W-1:0] tmr_tc_val;

   always_comb begin
      tmr_clr    = 1'b0;
      tmr_en     = 1'b0;
      tmr_low    = 1'b0;
      tmr_tc_val = WIN_MAX;
      case (state)
         ST_WAIT2: begin
            if (key_flag_p0) tmr_clr = 1'b1;
            else             tmr_en  = 1'b1;
         end
         ST_OS_RST: begin
            tmr_en     = 1'b1;
            tmr_low    = 1'b1;
            tmr_tc_val = {{(CNT_W-8){1'b0}}, RST_LEN};
         end
         default: tmr_clr = 1'b1;
      endcase
   end

   key_win_timer u_timer (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clr       (tmr_clr),
      .en        (tmr_en),
      .load      (1'b0),
      .load_val  ({CNT_W{1'b0}}),
      .tc_val    (tmr_tc_val),
      .tc_low    (tmr_low),
      .tc        (tmr_tc)
   );

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         key_flag_p0 <= 1'b0;
         state       <= ST_IDLE;
         ch_sel      <= 3'd0;
         os          <= OS_INIT;
         ad_rst_req  <= 1'b0;
         ch_chg      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         key_flag_p0 <= key_flag;
         ch_chg      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (key_flag_p0) begin
                  state <= ST_WAIT2;
                  busy  <= 1'b1;
               end
            end
            ST_WAIT2: begin
               // A press on the last window count still wins over the timeout.
               if (key_flag_p0) begin
                  os         <= os_next(os, OS_MAX);
                  ad_rst_req <= 1'b1;
                  state      <= ST_OS_RST;
               end else if (tmr_tc) begin
                  ch_sel <= ch_next(ch_sel);
                  ch_chg <= 1'b1;
                  state  <= ST_IDLE;
                  busy   <= 1'b0;
               end
            end
            ST_OS_RST: begin
               if (tmr_tc) begin
                  ad_rst_req <= 1'b0;
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
               end
            end
            default: begin
               ad_rst_req <= 1'b0;
               state      <= ST_IDLE;
               busy       <= 1'b0;
            end
         endcase
      end
   end

`else

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         key_flag_p0 <= 1'b0;
         ch_sel      <= 3'd0;
         ch_chg      <= 1'b0;
      end else begin
         key_flag_p0 <= key_flag;
         ch_chg      <= key_flag_p0;
         if (key_flag_p0) ch_sel <= ch_next(ch_sel);
      end
   end

   assign os         = OS_INIT;
   assign ad_rst_req = 1'b0;
   assign busy       = 1'b0;

   // Timing parameters only matter to the double-click build.
   logic unused_cfg;
   assign unused_cfg = ^{WIN_MAX, RST_LEN, OS_MAX};

`endif

endmodule
